// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-rate helper.
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  // System clocks per serial bit.
  function automatic int unsigned uart_rate(input int unsigned clock, input int unsigned baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchroniser for an asynchronous input; resets to the idle-high level.
module uart_rx_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1/8E1 UART receiver: mid-bit sampling, LSB-first reassembly, one-cycle result strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] val,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned RATE = uart_rate(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned HALF = RATE / 2;
  localparam int unsigned CW   = $clog2(RATE) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(RATE - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

  logic          rxs;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          acc, acc_n;
  logic          perr, perr_n;
  logic [7:0]    val_n;
  logic          valid_n, parity_err_n, frame_err_n, busy_n;

  uart_rx_sync #(.N(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      acc        <= 1'b0;
      perr       <= 1'b0;
      val        <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      acc        <= acc_n;
      perr       <= perr_n;
      val        <= val_n;
      valid      <= valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    shreg_n      = shreg;
    acc_n        = acc;
    perr_n       = perr;
    val_n        = val;
    valid_n      = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;
    busy_n       = busy;

    unique case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        cnt_n  = '0;
        if (!rxs) begin
          state_n = S_START;
          busy_n  = 1'b1;
        end
      end
      // Half a bit in: confirm the start bit, which also aligns later samples to mid-bit.
      S_START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end else begin
            idx_n   = '0;
            acc_n   = 1'b0;
            perr_n  = 1'b0;
            state_n = S_DATA;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          shreg_n = {rxs, shreg[7:1]};
          acc_n   = acc ^ rxs;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          perr_n  = (rxs != acc);
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      // Leaving at the stop-bit centre leaves half a bit to catch an immediately following start.
      S_STOP: begin
        if (cnt == BIT_END) begin
          cnt_n        = '0;
          val_n        = shreg;
          busy_n       = 1'b0;
          parity_err_n = perr;
          if (rxs) begin
            valid_n = !perr;
            state_n = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = S_WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: even-parity and no-parity instances at RATE=10.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int RATE  = 10;
  localparam int HALF  = 5;
  localparam int LAT_P = 2 + HALF + 8*RATE + RATE + RATE + 1;
  localparam int LAT_N = 2 + HALF + 8*RATE + RATE + 1;

  logic clk = 1'b0;
  logic rst;
  logic rx_p, rx_n;
  logic [7:0] val_p, val_n;
  logic valid_p, perr_p, ferr_p, busy_p;
  logic valid_n, perr_n, ferr_n, busy_n;

  uart_rx #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .val(val_p), .valid(valid_p),
    .parity_err(perr_p), .frame_err(ferr_p), .busy(busy_p)
  );

  uart_rx #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(0)) dut_n (
    .clk(clk), .rst(rst), .rx(rx_n), .val(val_n), .valid(valid_n),
    .parity_err(perr_n), .frame_err(ferr_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       v;
    logic       pe;
    logic       fe;
    logic [7:0] b;
    int         c;
  } ev_t;

  ev_t evq_p[$];
  ev_t evq_n[$];

  // Every cycle carrying any strobe becomes one event, so a stretched strobe shows as extra events.
  always @(negedge clk) begin
    ev_t e;
    if (valid_p || perr_p || ferr_p) begin
      e.v = valid_p; e.pe = perr_p; e.fe = ferr_p; e.b = val_p; e.c = cyc;
      evq_p.push_back(e);
    end
    if (valid_n || perr_n || ferr_n) begin
      e.v = valid_n; e.pe = perr_n; e.fe = ferr_n; e.b = val_n; e.c = cyc;
      evq_n.push_back(e);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Expected {valid, parity_err, frame_err} for one frame as seen on the line.
  function automatic logic [2:0] model(input logic [7:0] d, input logic pbit, input logic stop,
                                       input bit use_par);
    logic pe, fe;
    pe = use_par && (pbit != ^d);
    fe = !stop;
    return {(!pe && !fe), pe, fe};
  endfunction

  task automatic set_line(input bit sel, input logic b);
    if (sel) rx_p = b;
    else     rx_n = b;
  endtask

  // Called at a negedge; t0 is the cycle count at the start-bit falling edge.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit,
                            input logic stop, input bit use_par, output int t0);
    set_line(sel, 1'b0);
    t0 = cyc;
    repeat (RATE) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      repeat (RATE) @(negedge clk);
    end
    if (use_par) begin
      set_line(sel, pbit);
      repeat (RATE) @(negedge clk);
    end
    set_line(sel, stop);
    repeat (RATE) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_p = 1'b1; rx_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({val_p, valid_p, perr_p, ferr_p, busy_p} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_p got %h exp 000", {val_p, valid_p, perr_p, ferr_p, busy_p});
    end
    n_checks++;
    if ({val_n, valid_n, perr_n, ferr_n, busy_n} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_n got %h exp 000", {val_n, valid_n, perr_n, ferr_n, busy_n});
    end
    rst = 1'b0;
    repeat (2 * RATE) @(negedge clk);
    n_checks++;
    if (evq_p.size() + evq_n.size() != 0 || busy_p !== 1'b0 || busy_n !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle events %0d busy %b%b exp 0 events not busy",
               evq_p.size() + evq_n.size(), busy_p, busy_n);
    end
  endtask

  task automatic test_basic();
    int t0;
    evq_p.delete();
    send_frame(1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, t0);
    repeat (RATE) @(negedge clk);
    n_checks++;
    if (evq_p.size() != 1) begin
      n_errors++;
      $display("FAIL basic_count got %0d exp 1", evq_p.size());
    end else begin
      n_checks++;
      if ({evq_p[0].v, evq_p[0].pe, evq_p[0].fe} !== 3'b100 || evq_p[0].b !== 8'hA5) begin
        n_errors++;
        $display("FAIL basic_frame got strobes %b val %h exp 100 val a5",
                 {evq_p[0].v, evq_p[0].pe, evq_p[0].fe}, evq_p[0].b);
      end
      n_checks++;
      if (evq_p[0].c - t0 < LAT_P - 1 || evq_p[0].c - t0 > LAT_P + 1) begin
        n_errors++;
        $display("FAIL basic_latency got %0d exp %0d", evq_p[0].c - t0, LAT_P);
      end
    end
    n_checks++;
    if (busy_p !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_busy got %b exp 0", busy_p);
    end
  endtask

  task automatic test_random();
    int t0;
    logic [7:0] d;
    logic pbit, stop;
    logic [2:0] exp_s;
    for (int k = 0; k < 10; k++) begin
      d     = 8'($urandom);
      pbit  = (^d) ^ ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 3) != 0);
      exp_s = model(d, pbit, stop, 1'b1);
      evq_p.delete();
      send_frame(1'b1, d, pbit, stop, 1'b1, t0);
      rx_p = 1'b1;
      repeat (2 * RATE) @(negedge clk);
      n_checks++;
      if (evq_p.size() != 1) begin
        n_errors++;
        $display("FAIL random_count frame %0d got %0d exp 1", k, evq_p.size());
      end else if ({evq_p[0].v, evq_p[0].pe, evq_p[0].fe} !== exp_s || evq_p[0].b !== d) begin
        n_errors++;
        $display("FAIL random_frame %0d got strobes %b val %h exp %b val %h", k,
                 {evq_p[0].v, evq_p[0].pe, evq_p[0].fe}, evq_p[0].b, exp_s, d);
      end
    end
  endtask

  task automatic test_glitch();
    bit seen_busy;
    seen_busy = 1'b0;
    evq_p.delete();
    rx_p = 1'b0;
    for (int i = 1; i <= HALF + 4; i++) begin
      @(negedge clk);
      if (busy_p) seen_busy = 1'b1;
      if (i == 3) rx_p = 1'b1;
    end
    n_checks++;
    if (seen_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_busy_rise got %b exp 1", seen_busy);
    end
    n_checks++;
    if (busy_p !== 1'b0) begin
      n_errors++;
      $display("FAIL glitch_busy_fall got %b exp 0", busy_p);
    end
    repeat (12 * RATE) @(negedge clk);
    n_checks++;
    if (evq_p.size() != 0) begin
      n_errors++;
      $display("FAIL glitch_strobes got %0d events exp 0", evq_p.size());
    end
  endtask

  task automatic test_parity();
    int t0;
    evq_p.delete();
    send_frame(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, t0);
    repeat (RATE) @(negedge clk);
    n_checks++;
    if (evq_p.size() != 1 || {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} !== 3'b010
        || evq_p[0].b !== 8'h01) begin
      n_errors++;
      $display("FAIL parity_bad events %0d first %b val %h exp 1 event 010 val 01", evq_p.size(),
               (evq_p.size() > 0) ? {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} : 3'bxxx,
               (evq_p.size() > 0) ? evq_p[0].b : 8'hxx);
    end
    evq_p.delete();
    send_frame(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, t0);
    repeat (RATE) @(negedge clk);
    n_checks++;
    if (evq_p.size() != 1 || {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} !== 3'b100
        || evq_p[0].b !== 8'h03) begin
      n_errors++;
      $display("FAIL parity_good events %0d first %b val %h exp 1 event 100 val 03", evq_p.size(),
               (evq_p.size() > 0) ? {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} : 3'bxxx,
               (evq_p.size() > 0) ? evq_p[0].b : 8'hxx);
    end
  endtask

  task automatic test_break();
    int t0;
    evq_p.delete();
    send_frame(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, t0);
    repeat (30 * RATE) @(negedge clk);
    n_checks++;
    if (evq_p.size() != 1 || {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} !== 3'b001
        || evq_p[0].b !== 8'h55) begin
      n_errors++;
      $display("FAIL break_frame events %0d first %b val %h exp 1 event 001 val 55", evq_p.size(),
               (evq_p.size() > 0) ? {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} : 3'bxxx,
               (evq_p.size() > 0) ? evq_p[0].b : 8'hxx);
    end
    n_checks++;
    if (busy_p !== 1'b0) begin
      n_errors++;
      $display("FAIL break_busy got %b exp 0", busy_p);
    end
    rx_p = 1'b1;
    repeat (2 * RATE) @(negedge clk);
    evq_p.delete();
    send_frame(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, t0);
    repeat (RATE) @(negedge clk);
    n_checks++;
    if (evq_p.size() != 1 || {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} !== 3'b100
        || evq_p[0].b !== 8'h3C) begin
      n_errors++;
      $display("FAIL break_recover events %0d first %b val %h exp 1 event 100 val 3c", evq_p.size(),
               (evq_p.size() > 0) ? {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} : 3'bxxx,
               (evq_p.size() > 0) ? evq_p[0].b : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    evq_n.delete();
    send_frame(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, t0);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, t1);
    repeat (RATE) @(negedge clk);
    n_checks++;
    if (evq_n.size() != 2) begin
      n_errors++;
      $display("FAIL b2b_count got %0d exp 2", evq_n.size());
    end else begin
      n_checks++;
      if (!evq_n[0].v || !evq_n[1].v || evq_n[0].b !== 8'h00 || evq_n[1].b !== 8'hFF) begin
        n_errors++;
        $display("FAIL b2b_vals got v%b %h v%b %h exp v1 00 v1 ff",
                 evq_n[0].v, evq_n[0].b, evq_n[1].v, evq_n[1].b);
      end
      n_checks++;
      if (evq_n[1].c - evq_n[0].c != 10 * RATE) begin
        n_errors++;
        $display("FAIL b2b_spacing got %0d exp %0d", evq_n[1].c - evq_n[0].c, 10 * RATE);
      end
      n_checks++;
      if (evq_n[0].c - t0 < LAT_N - 1 || evq_n[0].c - t0 > LAT_N + 1) begin
        n_errors++;
        $display("FAIL b2b_latency got %0d exp %0d", evq_n[0].c - t0, LAT_N);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [7:0] d;
    d = 8'h5A;
    evq_p.delete();
    rx_p = 1'b0;
    repeat (RATE) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_p = d[i];
      repeat (RATE) @(negedge clk);
    end
    rx_p = d[4];
    repeat (HALF) @(negedge clk);
    n_checks++;
    if (busy_p !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_busy_before got %b exp 1", busy_p);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({val_p, valid_p, perr_p, ferr_p, busy_p} !== 12'h000 || val_n !== 8'h00) begin
      n_errors++;
      $display("FAIL midrst_outputs got %h val_n %h exp 000 00",
               {val_p, valid_p, perr_p, ferr_p, busy_p}, val_n);
    end
    rx_p = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * RATE) @(negedge clk);
    send_frame(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, t0);
    repeat (2 * RATE) @(negedge clk);
    n_checks++;
    if (evq_p.size() != 1 || {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} !== 3'b100
        || evq_p[0].b !== 8'hC3) begin
      n_errors++;
      $display("FAIL midrst_frame events %0d first %b val %h exp 1 event 100 val c3", evq_p.size(),
               (evq_p.size() > 0) ? {evq_p[0].v, evq_p[0].pe, evq_p[0].fe} : 3'bxxx,
               (evq_p.size() > 0) ? evq_p[0].b : 8'hxx);
    end
  endtask

  initial begin
    rst = 1'b1; rx_p = 1'b1; rx_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_random();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver for 8N1 / 8E1 frames, the receive-side counterpart of the team's UART transmitter. It samples an external `rx` line at mid-bit using the system clock and reassembles LSB-first data bytes. Each completed frame is presented as `val` with a one-cycle `valid` strobe, plus parity and framing error strobes. It sits between the board RX pin and the byte-consuming logic (command parser, FIFO).

Parameters:
CLOCK_RATE, 100000000, system clock frequency in Hz.
BAUD_RATE, 115200, line bit rate in bits/s. RATE = CLOCK_RATE/BAUD_RATE must be at least 4.
PARITY, 1, 1 = even parity bit expected after data bits (parity = XOR of the 8 data bits); 0 = no parity bit.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
rx  input  1  serial line, idle high, asynchronous to clk.
val  output  8  last received data byte, LSB received first.
valid  output  1  one-cycle pulse: good frame, `val` updated this cycle.
parity_err  output  1  one-cycle pulse: frame ended with bad parity (only when PARITY=1).
frame_err  output  1  one-cycle pulse: stop bit sampled low.
busy  output  1  high from start-bit detection until the frame completes or is rejected.

Behaviour:
- Reset (async, any state): val=0, valid=0, parity_err=0, frame_err=0, busy=0, synchroniser flops=1, state=S_IDLE, counter=0, bit index=0.
- `rx` passes through a 2-flop synchroniser, initialised high. All decisions use the synchronised value `rxs`, giving 2 cycles of input latency.
- Counter width is $clog2(RATE)+1. HALF = RATE/2, integer division.
- S_IDLE: busy=0. When `rxs`==0, go to S_START, counter=0, busy=1.
- S_START: at counter==HALF-1, sample `rxs`.
  - If 1 (glitch): return to S_IDLE with no strobes.
  - If 0: counter=0, idx=0, parity accumulator=0, go to S_DATA.
- S_DATA: every RATE cycles (counter==RATE-1), shift `rxs` into the MSB of the shift register and accumulate parity ^= rxs.
  - After idx==7, go to S_PARITY if PARITY=1, else go to S_STOP.
  - Samples land at mid-bit because S_START ended at the start bit's centre.
- S_PARITY: after RATE cycles, sample `rxs` and latch `perr` = (sample != accumulator). Go to S_STOP.
- S_STOP: after RATE cycles, sample `rxs`.
  - Next cycle, `val` is loaded from the shift register in every case, and busy drops to 0.
  - Stop=1 and no perr: pulse valid and go to S_IDLE.
  - Stop=1 and perr: pulse parity_err (no valid) and go to S_IDLE.
  - Stop=0: pulse frame_err (and parity_err if perr; no valid) and go to S_WAIT_HIGH.
- S_WAIT_HIGH (break or line fault): stay until `rxs`==1, then go to S_IDLE. No strobes are produced while the line is held low.
- Strobes are never asserted simultaneously with each other except frame_err together with parity_err.
- Latency: valid rises (2 + HALF + 8*RATE + PARITY*RATE + RATE + 1) cycles after the falling edge of `rx`, with exact equality within ±1 cycle.
- Back-to-back frames: a return to S_IDLE at the centre of the stop bit guarantees detection of a start bit that immediately follows a one-bit stop.
- The start bit is detected only on the low level in S_IDLE; a line held low at reset exit is treated as a start.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH (3 bits);
  - function uart_rate(clock, baud) returning CLOCK_RATE/BAUD_RATE, reused by the transmitter.
- One sub-module, uart_rx_sync: parameterised N-flop (default 2) synchroniser with async reset to 1.

Test Plan (CLOCK_RATE=1000000, BAUD_RATE=100000, RATE=10, PARITY=1 unless stated):
1. Drive 0xA5 with parity 0 and stop 1 -> val=0xA5, valid high exactly 1 cycle, no errors, busy low afterwards.
2. Pulse `rx` low for 3 cycles then high -> no valid/parity_err/frame_err; busy returns to 0 within HALF+3 cycles.
3. Drive 0x01 with parity bit 0 (wrong) -> val=0x01, parity_err pulse, valid stays 0. Then 0x03 with parity 0 -> valid, val=0x03.
4. Drive 0x55 with stop bit 0 and hold `rx` low for 30 bit times -> single frame_err pulse, nothing further. Release, then send 0x3C -> valid, val=0x3C.
5. PARITY=0: send 0x00 then 0xFF back-to-back with one stop bit each -> two valid pulses 10*RATE apart, val=0x00 then 0xFF.
6. Assert rst during bit 4 of 0x5A, deassert, then send 0xC3 -> outputs at reset values immediately on rst; only one valid, with val=0xC3.
